// File: rtl/cond_logic_banked.sv
// Banked condition-evaluation and control-gating stage for the pipelined core.
// Evaluates the ARM condition field against one of NUM_BANKS NZCV flag banks,
// gates PC/register/memory write requests with the result and optionally
// registers the gated controls as the EX/MEM boundary. Also keeps a
// saturating count of annulled (condition-failed) instructions.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   en, flush         stage enable (0 = stall), kill current instruction
//   bank_sel          active flag bank; out-of-range reads bank 0, no writes
//   Cond, ALUFlags    condition field, {N,Z,C,V} from the ALU
//   FlagW             [1] write N,Z  [0] write C,V
//   PCS, RegW, MemW   raw write requests; NoWrite suppresses RegW
//   clr_cnt           synchronous clear of annul_cnt
//   PCSrc, RegWrite, MemWrite, CondEx   gated controls
//   Flags             {N,Z,C,V} of the selected bank
//   annul_cnt         saturating annulled-instruction count
module cond_logic_banked #(
    parameter int unsigned NUM_BANKS   = 2,
    parameter int unsigned REG_OUTPUTS = 1,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned SEL_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [SEL_W-1:0] bank_sel,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             clr_cnt,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] annul_cnt
);

    logic [3:0]       bank_q [NUM_BANKS];
    logic [3:0]       flags_cur;
    logic             sel_ok;
    logic             cond_ok_raw;
    logic             cond_ok;
    logic             pc;
    logic             rw;
    logic             mw;
    logic             flag_we;
    logic             annul_hit;
    logic [CNT_W-1:0] cnt_q;

    // Bank read mux; an unmatched select falls back to bank 0 and is flagged invalid.
    always_comb begin
        flags_cur = bank_q[0];
        sel_ok    = 1'b0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (bank_sel == SEL_W'(b)) begin
                flags_cur = bank_q[b];
                sel_ok    = 1'b1;
            end
        end
    end

    // Condition decode on {N,Z,C,V} = flags_cur[3:0].
    always_comb begin
        cond_ok_raw = 1'b1;
        case (Cond)
            4'h0:    cond_ok_raw = flags_cur[2];
            4'h1:    cond_ok_raw = ~flags_cur[2];
            4'h2:    cond_ok_raw = flags_cur[1];
            4'h3:    cond_ok_raw = ~flags_cur[1];
            4'h4:    cond_ok_raw = flags_cur[3];
            4'h5:    cond_ok_raw = ~flags_cur[3];
            4'h6:    cond_ok_raw = flags_cur[0];
            4'h7:    cond_ok_raw = ~flags_cur[0];
            4'h8:    cond_ok_raw = flags_cur[1] & ~flags_cur[2];
            4'h9:    cond_ok_raw = ~flags_cur[1] | flags_cur[2];
            4'hA:    cond_ok_raw = (flags_cur[3] == flags_cur[0]);
            4'hB:    cond_ok_raw = (flags_cur[3] != flags_cur[0]);
            4'hC:    cond_ok_raw = ~flags_cur[2] & (flags_cur[3] == flags_cur[0]);
            4'hD:    cond_ok_raw = flags_cur[2] | (flags_cur[3] != flags_cur[0]);
            default: cond_ok_raw = 1'b1;
        endcase
    end

    assign cond_ok   = cond_ok_raw & ~flush;
    assign pc        = PCS & cond_ok;
    assign rw        = RegW & cond_ok & ~NoWrite;
    assign mw        = MemW & cond_ok;
    assign flag_we   = en & cond_ok & sel_ok;
    // Flush is checked explicitly because the count uses the unmasked decode.
    assign annul_hit = en & ~flush & ~cond_ok_raw & (PCS | RegW | MemW | (|FlagW));

    // Flag banks: only the selected, valid bank is written, N/Z and C/V independently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                bank_q[b] <= 4'b0000;
            end
        end else if (flag_we) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                if (bank_sel == SEL_W'(b)) begin
                    if (FlagW[1]) bank_q[b][3:2] <= ALUFlags[3:2];
                    if (FlagW[0]) bank_q[b][1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // Annul counter: clear wins, increment saturates at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (annul_hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign Flags     = flags_cur;
    assign annul_cnt = cnt_q;

    generate
        if (REG_OUTPUTS != 0) begin : g_reg
            logic pc_q;
            logic rw_q;
            logic mw_q;
            logic cx_q;

            // EX/MEM boundary; flush reaches here as cond_ok=0, stall holds.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pc_q <= 1'b0;
                    rw_q <= 1'b0;
                    mw_q <= 1'b0;
                    cx_q <= 1'b0;
                end else if (en) begin
                    pc_q <= pc;
                    rw_q <= rw;
                    mw_q <= mw;
                    cx_q <= cond_ok;
                end
            end

            assign PCSrc    = pc_q;
            assign RegWrite = rw_q;
            assign MemWrite = mw_q;
            assign CondEx   = cx_q;
        end else begin : g_comb
            assign PCSrc    = pc;
            assign RegWrite = rw;
            assign MemWrite = mw;
            assign CondEx   = cond_ok;
        end
    endgenerate

endmodule

// File: tb/tb_cond_logic_banked.sv
// Bench for cond_logic_banked: a registered 2-bank / 16-bit-counter instance
// driven from a vector table through an expected-result queue, plus a
// combinational 3-bank / 2-bit-counter instance exercised by hand sequences.
module tb_cond_logic_banked;

    logic       clk;
    logic       reset;
    logic       en;
    logic       flush;
    logic [0:0] sel_a;
    logic [1:0] sel_b;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowr;
    logic       clr;

    logic        pc_a, rw_a, mw_a, cx_a;
    logic [3:0]  flags_a;
    logic [15:0] cnt_a;
    logic        pc_b, rw_b, mw_b, cx_b;
    logic [3:0]  flags_b;
    logic [1:0]  cnt_b;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    cond_logic_banked #(.NUM_BANKS(2), .REG_OUTPUTS(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .bank_sel(sel_a),
        .Cond(cond), .ALUFlags(alu), .FlagW(fw), .PCS(pcs), .RegW(regw),
        .MemW(memw), .NoWrite(nowr), .clr_cnt(clr),
        .PCSrc(pc_a), .RegWrite(rw_a), .MemWrite(mw_a), .CondEx(cx_a),
        .Flags(flags_a), .annul_cnt(cnt_a)
    );

    cond_logic_banked #(.NUM_BANKS(3), .REG_OUTPUTS(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .bank_sel(sel_b),
        .Cond(cond), .ALUFlags(alu), .FlagW(fw), .PCS(pcs), .RegW(regw),
        .MemW(memw), .NoWrite(nowr), .clr_cnt(clr),
        .PCSrc(pc_b), .RegWrite(rw_b), .MemWrite(mw_b), .CondEx(cx_b),
        .Flags(flags_b), .annul_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic       en, flush;
        logic [0:0] sel;
        logic [3:0] cond, alu;
        logic [1:0] fw;
        logic       pcs, regw, memw, nw, clr;
        logic       pc, rw, mw, cx;
        logic [3:0] flags;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input int e, input int f, input int s, input int c,
                                input int a, input int w, input int p, input int r,
                                input int m, input int n, input int k,
                                input int xpc, input int xrw, input int xmw,
                                input int xcx, input int xfl, input int xcnt);
        vec_t v;
        v.en = 1'(e);     v.flush = 1'(f);  v.sel = 1'(s);
        v.cond = 4'(c);   v.alu = 4'(a);    v.fw = 2'(w);
        v.pcs = 1'(p);    v.regw = 1'(r);   v.memw = 1'(m);
        v.nw = 1'(n);     v.clr = 1'(k);
        v.pc = 1'(xpc);   v.rw = 1'(xrw);   v.mw = 1'(xmw);
        v.cx = 1'(xcx);   v.flags = 4'(xfl); v.cnt = 16'(xcnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        en = v.en; flush = v.flush; sel_a = v.sel; cond = v.cond; alu = v.alu;
        fw = v.fw; pcs = v.pcs; regw = v.regw; memw = v.memw; nowr = v.nw; clr = v.clr;
    endtask

    task automatic idle_inputs();
        en = 1'b1; flush = 1'b0; sel_a = 1'b0; sel_b = 2'd0; cond = 4'hE; alu = 4'h0;
        fw = 2'b00; pcs = 1'b0; regw = 1'b0; memw = 1'b0; nowr = 1'b0; clr = 1'b0;
    endtask

    initial begin
        vec_t v;
        vec_t e;

        //        en fl sl cond alu fw pc rw mw nw cl | pc rw mw cx flags cnt
        vecs.push_back(mk(1,0,0,'hE,'h4,2, 0,1,0,0,0,  0,1,0,1,'h4,0)); // write N,Z on bank 0
        vecs.push_back(mk(1,0,0,'h0,'h0,0, 0,1,1,0,0,  0,1,1,1,'h4,0)); // EQ passes
        vecs.push_back(mk(1,0,0,'h0,'h0,0, 0,1,1,1,0,  0,0,1,1,'h4,0)); // NoWrite
        vecs.push_back(mk(1,0,0,'h1,'h0,0, 1,0,0,0,0,  0,0,0,0,'h4,1)); // NE annulled x3
        vecs.push_back(mk(1,0,0,'h1,'h0,0, 1,0,0,0,0,  0,0,0,0,'h4,2));
        vecs.push_back(mk(1,0,0,'h1,'h0,0, 1,0,0,0,0,  0,0,0,0,'h4,3));
        vecs.push_back(mk(1,0,0,'h1,'h0,0, 1,0,0,0,1,  0,0,0,0,'h4,0)); // clear beats annul
        vecs.push_back(mk(1,0,1,'hE,'hA,3, 0,0,0,0,0,  0,0,0,1,'hA,0)); // bank 1 = 1010
        vecs.push_back(mk(1,0,0,'hB,'h0,0, 0,1,0,0,0,  0,0,0,0,'h4,1)); // LT fails on bank 0
        vecs.push_back(mk(1,0,1,'hB,'h0,0, 0,1,0,0,0,  0,1,0,1,'hA,1)); // LT passes on bank 1
        vecs.push_back(mk(1,0,1,'hC,'h0,0, 1,0,0,0,0,  0,0,0,0,'hA,2)); // GT fails
        vecs.push_back(mk(1,0,1,'hD,'h0,0, 1,0,0,0,0,  1,0,0,1,'hA,2)); // LE passes
        vecs.push_back(mk(0,0,1,'hE,'h0,3, 0,1,1,0,0,  1,0,0,1,'hA,2)); // stall holds
        vecs.push_back(mk(0,0,1,'h0,'h0,0, 1,0,0,0,0,  1,0,0,1,'hA,2)); // stalled fail not counted
        vecs.push_back(mk(1,1,1,'hE,'h5,3, 0,1,0,0,0,  0,0,0,0,'hA,2)); // flush: no load, no flag write
        vecs.push_back(mk(1,1,1,'h0,'h0,0, 1,0,0,0,0,  0,0,0,0,'hA,2)); // flushed fail not counted
        vecs.push_back(mk(1,0,1,'hE,'h0,0, 1,0,0,0,0,  1,0,0,1,'hA,2));
        vecs.push_back(mk(0,1,1,'hE,'h0,0, 0,1,0,0,0,  1,0,0,1,'hA,2)); // stall beats flush
        vecs.push_back(mk(0,0,1,'hE,'h0,0, 0,0,0,0,1,  1,0,0,1,'hA,0)); // clear while stalled
        vecs.push_back(mk(1,0,0,'h8,'h0,0, 0,0,1,0,0,  0,0,0,0,'h4,1)); // HI fails
        vecs.push_back(mk(1,0,0,'h2,'h3,1, 0,0,0,0,0,  0,0,0,0,'h4,2)); // CS fails, FlagW-only counts
        vecs.push_back(mk(1,0,0,'hE,'h3,1, 0,0,0,0,0,  0,0,0,1,'h7,2)); // write C,V only
        vecs.push_back(mk(1,0,0,'h8,'h0,0, 0,0,1,0,0,  0,0,0,0,'h7,3)); // HI fails (Z=1)
        vecs.push_back(mk(1,0,0,'h9,'h0,0, 0,0,1,0,0,  0,0,1,1,'h7,3)); // LS passes
        vecs.push_back(mk(1,0,0,'h6,'h0,0, 1,0,0,0,0,  1,0,0,1,'h7,3)); // VS passes
        vecs.push_back(mk(1,0,0,'h7,'h0,0, 1,0,0,0,0,  0,0,0,0,'h7,4)); // VC fails
        vecs.push_back(mk(1,0,0,'h4,'h0,0, 0,1,0,0,0,  0,0,0,0,'h7,5)); // MI fails
        vecs.push_back(mk(1,0,0,'h5,'h0,0, 0,1,0,0,0,  0,1,0,1,'h7,5)); // PL passes
        vecs.push_back(mk(1,0,0,'h3,'h0,0, 1,0,0,0,0,  0,0,0,0,'h7,6)); // CC fails
        vecs.push_back(mk(1,0,0,'hA,'h0,0, 0,1,0,0,0,  0,0,0,0,'h7,7)); // GE fails (N0 V1)
        vecs.push_back(mk(1,0,0,'hF,'h0,0, 0,0,1,0,0,  0,0,1,1,'h7,7)); // 1111 always
        vecs.push_back(mk(1,0,0,'hE,'h8,2, 0,0,0,0,0,  0,0,0,1,'hB,7)); // N,Z = 10
        vecs.push_back(mk(1,0,0,'hA,'h0,0, 0,1,0,0,0,  0,1,0,1,'hB,7)); // GE passes (N1 V1)
        vecs.push_back(mk(1,0,0,'h0,'h0,0, 0,0,0,0,0,  0,0,0,0,'hB,7)); // fail, no request
        vecs.push_back(mk(1,0,0,'h0,'hF,3, 0,0,0,0,0,  0,0,0,0,'hB,8)); // fail with FlagW: count, no write

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst flags_a", 32'(flags_a), 32'h0);
        chk("rst outs_a", 32'({pc_a, rw_a, mw_a, cx_a}), 32'h0);
        chk("rst cnt_a", 32'(cnt_a), 32'h0);
        chk("rst cnt_b", 32'(cnt_b), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Table: expected pushed at drive time, popped once the edge has produced it.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d PCSrc", i),    32'(pc_a),    32'(e.pc));
            chk($sformatf("v%0d RegWrite", i), 32'(rw_a),    32'(e.rw));
            chk($sformatf("v%0d MemWrite", i), 32'(mw_a),    32'(e.mw));
            chk($sformatf("v%0d CondEx", i),   32'(cx_a),    32'(e.cx));
            chk($sformatf("v%0d Flags", i),    32'(flags_a), 32'(e.flags));
            chk($sformatf("v%0d annul_cnt", i), 32'(cnt_a),  32'(e.cnt));
        end

        // Mid-cycle asynchronous reset with a flag write pending.
        @(negedge clk);
        idle_inputs();
        fw = 2'b11; alu = 4'hF; pcs = 1'b1; regw = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("arst flags_a", 32'(flags_a), 32'h0);
        chk("arst cnt_a", 32'(cnt_a), 32'h0);
        chk("arst outs_a", 32'({pc_a, rw_a, mw_a, cx_a}), 32'h0);
        @(posedge clk);
        #1;
        chk("arst held flags_a", 32'(flags_a), 32'h0);
        chk("arst held outs_a", 32'({pc_a, rw_a, mw_a, cx_a}), 32'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        sel_a = 1'b1;
        #1;
        chk("arst bank1_a", 32'(flags_a), 32'h0);
        chk("arst flags_b", 32'(flags_b), 32'h0);

        // Combinational instance: GT with N=V=1, Z=0, then flush in the same cycle.
        @(negedge clk);
        idle_inputs();
        fw = 2'b11; alu = 4'h9;
        @(posedge clk);
        #1;
        chk("b flags 1001", 32'(flags_b), 32'h9);
        @(negedge clk);
        fw = 2'b00; cond = 4'hC; pcs = 1'b1;
        #1;
        chk("b GT PCSrc", 32'(pc_b), 32'h1);
        chk("b GT CondEx", 32'(cx_b), 32'h1);
        flush = 1'b1;
        #1;
        chk("b flush PCSrc", 32'(pc_b), 32'h0);
        chk("b flush CondEx", 32'(cx_b), 32'h0);
        flush = 1'b0;

        // 2-bit counter saturates at 3.
        @(negedge clk);
        cond = 4'h0; pcs = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b sat %0d", k), 32'(cnt_b), (k < 3) ? 32'(k + 1) : 32'h3);
        end
        chk("b flags after annul", 32'(flags_b), 32'h9);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("b clr with annul", 32'(cnt_b), 32'h0);

        // Out-of-range bank: evaluates bank 0, writes nothing.
        @(negedge clk);
        idle_inputs();
        sel_b = 2'd3; cond = 4'hC; pcs = 1'b1;
        #1;
        chk("b sel3 GT PCSrc", 32'(pc_b), 32'h1);
        chk("b sel3 Flags", 32'(flags_b), 32'h9);
        @(negedge clk);
        cond = 4'hE; pcs = 1'b0; fw = 2'b11; alu = 4'h6;
        @(posedge clk);
        #1;
        chk("b sel3 no write", 32'(flags_b), 32'h9);
        sel_b = 2'd1;
        #1;
        chk("b bank1 untouched", 32'(flags_b), 32'h0);
        sel_b = 2'd2;
        #1;
        chk("b bank2 untouched", 32'(flags_b), 32'h0);
        @(negedge clk);
        fw = 2'b00;
        sel_b = 2'd0;
        #1;
        chk("b bank0 untouched", 32'(flags_b), 32'h9);

        // Write bank 2 only.
        @(negedge clk);
        sel_b = 2'd2; fw = 2'b11; alu = 4'h6;
        @(posedge clk);
        #1;
        chk("b bank2 written", 32'(flags_b), 32'h6);
        sel_b = 2'd0;
        #1;
        chk("b bank0 after bank2 write", 32'(flags_b), 32'h9);

        @(negedge clk);
        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/cond_logic_banked.md
Name: cond_logic_banked

Overview:
- Parametrised successor to the single-cycle condition/control-gating logic, for the pipelined core.
- Evaluates the 4-bit ARM condition field against a banked NZCV flag register. One flag bank per processor mode.
- Gates PCSrc, RegWrite and MemWrite with the result, and optionally registers these outputs as the EX/MEM stage boundary.
- Adds stall and flush handling and a saturating annulled-instruction counter for performance debug.

Parameters:
- NUM_BANKS, 2, number of NZCV flag banks (1..8); selected by bank_sel.
- REG_OUTPUTS, 1, 1 = PCSrc/RegWrite/MemWrite/CondEx registered (1-cycle latency); 0 = combinational.
- CNT_W, 16, width of the annulled-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  stage enable; 0 = stall (hold all state).
- flush  in  1  kill instruction in this stage.
- bank_sel  in  max(1,$clog2(NUM_BANKS))  active flag bank.
- Cond  in  4  instruction condition field.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  2  [1] = write N,Z; [0] = write C,V.
- PCS  in  1  PC-write request.
- RegW  in  1  register-write request.
- MemW  in  1  memory-write request.
- NoWrite  in  1  suppress register write (CMP/TST class).
- clr_cnt  in  1  synchronous clear of annul_cnt.
- PCSrc  out  1  gated PCS.
- RegWrite  out  1  gated RegW.
- MemWrite  out  1  gated MemW.
- CondEx  out  1  condition passed.
- Flags  out  4  current {N,Z,C,V} of the selected bank.
- annul_cnt  out  CNT_W  count of annulled instructions.

Behaviour:

Reset (reset=0, asynchronous):
- All flag banks = 4'b0000.
- annul_cnt = 0.
- Registered PCSrc/RegWrite/MemWrite/CondEx = 0.
- Reset mid-operation discards any pending update.

Condition decode (combinational, selected bank {N,Z,C,V}):
- 0000 EQ: Z. 0001 NE: !Z.
- 0010 CS: C. 0011 CC: !C.
- 0100 MI: N. 0101 PL: !N.
- 0110 VS: V. 0111 VC: !V.
- 1000 HI: C&!Z. 1001 LS: !C|Z.
- 1010 GE: N==V. 1011 LT: N!=V.
- 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
- 1110 AL: 1. 1111: 1 (treated as AL).
- The internal cond_ok signal is forced to 0 when flush=1.

Gating:
- pc = PCS & cond_ok.
- rw = RegW & cond_ok & !NoWrite.
- mw = MemW & cond_ok.
- REG_OUTPUTS=0: outputs equal pc/rw/mw/cond_ok directly.
- REG_OUTPUTS=1, on each rising edge:
  - en=1: outputs load pc/rw/mw/cond_ok.
  - en=0: outputs hold.
  - flush=1 with en=1: outputs load 0.
  - flush=1 with en=0: flush is ignored; stall has priority.

Flag update (rising edge, selected bank only, when en=1 and flush=0 and cond_ok=1):
- FlagW[1]=1: N,Z <= ALUFlags[3:2].
- FlagW[0]=1: C,V <= ALUFlags[1:0].
- Other banks are never written.
- The new flags are visible on Flags and in evaluation from the next cycle; there is no same-cycle bypass.

bank_sel:
- Takes effect combinationally for both evaluation and update.
- If bank_sel >= NUM_BANKS: evaluate using bank 0 and inhibit all flag writes.

Annul counter (rising edge):
- clr_cnt=1: annul_cnt <= 0, regardless of en. Clear has priority over increment.
- Otherwise, if en & !flush & !cond_ok_raw & (PCS|RegW|MemW|FlagW!=0): increment, saturating at 2^CNT_W-1 (no wrap).
- cond_ok_raw is the decode result before flush masking.
- Flushed and stalled instructions are never counted.

Test Plan:
- Reset: drive reset=0 at mid-cycle with FlagW=2'b11 and ALUFlags=4'hF pending -> Flags=0, all outputs 0 immediately, annul_cnt=0.
- Flag write / decode: bank 0, Cond=1110, FlagW=2'b10, ALUFlags=4'b0100, RegW=1 -> next cycle Flags=4'b0100. Then Cond=0000 (EQ), RegW=1, MemW=1 -> REG_OUTPUTS=1: RegWrite=1, MemWrite=1 one edge later. NoWrite=1 -> RegWrite=0, MemWrite=1.
- Annul: Flags Z=1, Cond=0001 (NE), PCS=1 for 3 cycles -> PCSrc=0, CondEx=0, annul_cnt=3, flags unchanged. With CNT_W=2: 5 such cycles -> annul_cnt saturates at 3. clr_cnt=1 together with an annul -> annul_cnt=0.
- Banking: NUM_BANKS=2; write NZCV=1010 into bank 1, then bank_sel=0 -> Flags=0000 and Cond=1011 (LT) fails. bank_sel=1 -> Flags=1010 and LT passes. With NUM_BANKS=3, bank_sel=3 and FlagW=11 -> no bank changes.
- Stall/flush: REG_OUTPUTS=1, outputs showing PCSrc=1. en=0 for 2 cycles with new inputs -> outputs, flags and counter hold. en=1, flush=1, Cond=AL, RegW=1, FlagW=11 -> outputs 0 next edge, flags unchanged, annul_cnt unchanged.
- Combinational mode: REG_OUTPUTS=0, Cond=1100 (GT), flags N=V=1, Z=0, PCS=1 -> PCSrc=1 same cycle. Assert flush=1 -> PCSrc=0 same cycle.
